// File: rtl/egu_par_initiator.sv
// rtl/egu_par_initiator.sv - PAR-bus initiator that triggers tasks and polls/clears events per command
module egu_par_initiator #(
    parameter int PAR_AW     = 12,
    parameter int PAR_DW     = 32,
    parameter int PAR_WW     = 4,
    parameter int NUM_TASKS  = 8,
    parameter int NUM_EVENTS = 8,
    parameter int TASK_BASE  = 'h000,
    parameter int EVENT_BASE = 'h100,
    parameter int POLL_GAP   = 4,
    parameter int MAX_POLLS  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_idx,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [7:0]        rsp_polls,
    output logic              par_sel,
    output logic              par_we,
    output logic [PAR_AW-1:0] par_addr,
    output logic [PAR_DW-1:0] par_wdata,
    output logic [PAR_WW-1:0] par_wstrb,
    input  logic              par_ready,
    input  logic [PAR_DW-1:0] par_rdata
);
    localparam int GW = $clog2(POLL_GAP + 2);

    typedef enum logic [2:0] {IDLE, TASK_WR, EVT_RD, GAP, EVT_CLR, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      status_q, status_d;
    logic [7:0]      polls_q, polls_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            done_q;
    logic            bus_state, xfer, bad_idx;
    logic [PAR_AW-1:0] task_addr, evt_addr;
    logic            unused_rdata;

    assign unused_rdata = ^par_rdata[PAR_DW-1:1];

    assign bad_idx = (((cmd_op == 2'b00) || (cmd_op == 2'b10)) && ({29'd0, cmd_idx} >= NUM_TASKS)) ||
                     ((cmd_op != 2'b00) && ({29'd0, cmd_idx} >= NUM_EVENTS));

    assign task_addr = PAR_AW'(TASK_BASE)  + PAR_AW'({idx_q, 2'b00});
    assign evt_addr  = PAR_AW'(EVENT_BASE) + PAR_AW'({idx_q, 2'b00});

    // done_q forces one deselected cycle after every completion so transfers never merge
    assign bus_state = (state_q == TASK_WR) || (state_q == EVT_RD) || (state_q == EVT_CLR);
    assign par_sel   = bus_state && !done_q;
    assign xfer      = par_sel && par_ready;
    assign par_we    = par_sel && (state_q != EVT_RD);
    assign par_addr  = !par_sel ? '0 : ((state_q == TASK_WR) ? task_addr : evt_addr);
    assign par_wdata = (par_sel && (state_q == TASK_WR)) ? PAR_DW'(1) : '0;
    assign par_wstrb = par_we ? '1 : '0;

    assign cmd_ready  = rst_n && (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_status = status_q;
    assign rsp_polls  = polls_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        status_d = status_q;
        polls_d  = polls_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    idx_d    = cmd_idx;
                    polls_d  = 8'd0;
                    status_d = 2'b00;
                    if (bad_idx) begin
                        status_d = 2'b10;
                        state_d  = RESP;
                    end else begin
                        case (cmd_op)
                            2'b01:   state_d = EVT_RD;
                            2'b11:   state_d = EVT_CLR;
                            default: state_d = TASK_WR;
                        endcase
                    end
                end
            end
            TASK_WR: begin
                if (xfer) state_d = (op_q == 2'b10) ? EVT_RD : RESP;
            end
            EVT_RD: begin
                if (xfer) begin
                    polls_d = polls_q + 8'd1;
                    if (par_rdata[0]) begin
                        state_d = EVT_CLR;
                    end else if (polls_q + 8'd1 == 8'(MAX_POLLS)) begin
                        status_d = 2'b01;
                        state_d  = RESP;
                    end else if (POLL_GAP == 0) begin
                        state_d = EVT_RD;
                    end else begin
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) state_d = EVT_RD;
                else                            gap_d   = gap_q + GW'(1);
            end
            EVT_CLR: begin
                if (xfer) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            idx_q    <= 3'd0;
            status_q <= 2'b00;
            polls_q  <= 8'd0;
            gap_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            polls_q  <= polls_d;
            gap_q    <= gap_d;
            done_q   <= xfer;
        end
    end
endmodule
